load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly upstream of the `memory` module: it converts RV32I load/store requests from the execute stage into single memory accesses, then returns the result.
- Drives the `memory` port set: byte address, write width, write enable and LSB-aligned write data.
- Captures the registered read word and sign- or zero-extends loads.
- Flags illegal or misaligned accesses.

Parameters:
- RAM_BASE, 32'h800: first RAM byte address; informational only, used by the bench for ROM/RAM stimulus.
- XLEN, package constant (32): data/address width; taken from isa_types, not overridable.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  XLEN  byte address (rs1 + imm, already summed)
- req_wdata  in  XLEN  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors
- resp_error  out  1  valid with resp_valid; illegal funct3 or trapped misalignment
- mem_addr  out  XLEN  to memory addr
- mem_wwidth  out  write_width_t  to memory wwidth
- mem_wenable  out  1  to memory wenable
- mem_wdata  out  XLEN  to memory wdata
- mem_rdata  in  XLEN  from memory rdata; valid the cycle after mem_addr is held; LSB = byte at mem_addr

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset puts the FSM in IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_error=0, mem_addr=0, mem_wenable=0, mem_wdata=0, mem_wwidth=word; req_ready=1 after reset.
- IDLE, on req_valid & req_ready: latch is_store, funct3, addr and wdata; decode.
  - Legal and aligned: go to ISSUE.
  - Illegal funct3 (loads 3/6/7, stores >=3): go to DONE with error=1; no memory access.
- ISSUE (1 cycle):
  - mem_addr = latched addr.
  - mem_wwidth from funct3[1:0].
  - mem_wdata = latched wdata.
  - mem_wenable = is_store & ~reset.
  - Next state: store -> DONE; load -> WAIT.
- WAIT (1 cycle): mem_addr is still held; capture mem_rdata and extend it. Next state: DONE.
  - LB: sign-extend bits [7:0].
  - LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LHU: zero-extend bits [15:0].
  - LW: pass bits [31:0] through.
- DONE (1 cycle): resp_valid=1 with registered rdata/error; next state IDLE. There is no response backpressure.
- Latency from accept edge to resp_valid:
  - load: 3 cycles
  - store: 2 cycles
  - error: 1 cycle
- Throughput: at most one request in flight; req_ready=0 outside IDLE.
- mem_wenable is high only in ISSUE for stores: exactly one pulse per store. mem_addr holds its last value otherwise.
- Stores to ROM addresses are issued normally; the memory ignores them.
- Reset in any state: the next state is IDLE and any pending response is dropped. A store in ISSUE when reset is high does not write.
- req_valid while not ready: ignored; the requester must hold it.
- Address wrap: no wrap checking; the address is passed through unchanged.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> DONE with resp_error=1, resp_rdata=0 and no memory access.
- Undefined: misaligned accesses are issued unchanged to memory; the memory's own byte handling applies and resp_error=0.

Decomposition:
- Shared package lsu_types:
  - lsu_state_t enum
  - funct3 localparams: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5
  - function funct3 -> write_width_t
- XLEN and write_width_t are reused from isa_types.
- One natural sub-module: load_extend, combinational, (funct3, rdata) -> extended word. It is instantiated in the WAIT capture path.

Test Plan:
- SW addr=0x800 data=0xDEADBEEF -> one mem_wenable pulse in ISSUE with mem_addr=0x800, width=word; resp_valid 2 cycles after accept, error=0.
- After that store:
  - LB 0x800 -> 0xFFFFFFEF
  - LBU 0x803 -> 0x000000DE
  - LH 0x802 -> 0xFFFFDEAD
  - LHU 0x800 -> 0x0000BEEF
  - each resp_valid 3 cycles after accept.
- LW 0x801:
  - with LSU_MISALIGN_TRAP_EN: resp_valid the next cycle, error=1, rdata=0, no mem_wenable.
  - without it: normal 3-cycle load, error=0.
- Load funct3=3 -> error=1 after 1 cycle, no access. Store funct3=4 -> same.
- SW 0x10 (ROM) then LW 0x10 -> load returns the original ROM word.
- Reset asserted during ISSUE of SW 0x804 -> mem_wenable stays 0, no resp_valid; a subsequent LW 0x804 returns the previous value, and req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/isa_types.sv
// Shared RV32I ISA types: datapath width and memory write-width encoding.
package isa_types;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WidthByte = 2'd0,
        WidthHalf = 2'd1,
        WidthWord = 2'd2
    } write_width_t;

endpackage

// File: rtl/load_store_unit_pkg.sv
// Load/store unit types: FSM states, RV32I funct3 codes and decode helpers.
// Misaligned-access trapping is selected in the top by LSU_MISALIGN_TRAP_EN.
package lsu_types;

    import isa_types::*;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    function automatic write_width_t funct3_to_width(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return WidthByte;
            2'b01:   return WidthHalf;
            default: return WidthWord;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load result formatting: sign/zero extension of the read word by funct3.
module load_extend
    import isa_types::*;
    import lsu_types::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] rdata_o
);

    always_comb begin
        rdata_o = rdata_i;
        case (funct3_i)
            F3_B:    rdata_o = {{(XLEN-8){rdata_i[7]}}, rdata_i[7:0]};
            F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, rdata_i[7:0]};
            F3_H:    rdata_o = {{(XLEN-16){rdata_i[15]}}, rdata_i[15:0]};
            F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, rdata_i[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, issued to a registered-read byte memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module load_store_unit
    import isa_types::*;
    import lsu_types::*;
#(
    parameter logic [XLEN-1:0] RAM_BASE = 32'h800
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_store,
    input  logic [2:0]         req_funct3,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               resp_valid,
    output logic [XLEN-1:0]    resp_rdata,
    output logic               resp_error,
    output logic [XLEN-1:0]    mem_addr,
    output write_width_t       mem_wwidth,
    output logic               mem_wenable,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata
);

    // RAM_BASE only documents the memory map; the unit never decodes it.
    logic unused_ram_base;
    assign unused_ram_base = ^RAM_BASE;

    lsu_state_t   state_q, state_d;
    logic         is_store_q, is_store_d;
    logic [2:0]   funct3_q, funct3_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    write_width_t mem_wwidth_q, mem_wwidth_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic         error_q, error_d;
    logic [XLEN-1:0] ext_rdata;
    logic         misaligned;
    logic         access_ok;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign access_ok = funct3_legal(req_is_store, req_funct3) && !misaligned;

    load_extend u_load_extend (
        .funct3_i (funct3_q),
        .rdata_i  (mem_rdata),
        .rdata_o  (ext_rdata)
    );

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wwidth_d = mem_wwidth_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    rdata_d    = '0;
                    if (access_ok) begin
                        error_d      = 1'b0;
                        mem_addr_d   = req_addr;
                        mem_wdata_d  = req_wdata;
                        mem_wwidth_d = funct3_to_width(req_funct3);
                        state_d      = StIssue;
                    end else begin
                        // Rejected requests never touch the memory port.
                        error_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StIssue: state_d = is_store_q ? StDone : StWait;
            StWait: begin
                rdata_d = ext_rdata;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wwidth_q <= WidthWord;
            rdata_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wwidth_q <= mem_wwidth_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign resp_valid  = (state_q == StDone);
    assign resp_rdata  = rdata_q;
    assign resp_error  = error_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wwidth  = mem_wwidth_q;
    // Gated by reset so a store caught in ISSUE by reset never writes.
    assign mem_wenable = (state_q == StIssue) && is_store_q && !reset;

endmodule
